// File: rtl/rr_bus_arbiter.sv
// Round-robin arbiter for a shared address bus: one owner at a time, one-cycle turnaround gap.
// Optional hold-limit watchdog enabled by defining ARB_WATCHDOG_EN.
module rr_bus_arbiter #(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned AW       = 8,
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*AW-1:0] addr_in,
  output logic [NREQ-1:0]    gnt,
  output logic [AW-1:0]      bus_addr,
  output logic               bus_valid,
  output logic               busy,
  output logic               timeout
);

  localparam int unsigned IW = (NREQ > 2) ? $clog2(NREQ) : 1;

  if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
    $error("rr_bus_arbiter: NREQ out of range 2..8");
  end
  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_hold
    $error("rr_bus_arbiter: MAX_HOLD out of range 2..255");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   last_q, last_d;
  logic [IW-1:0]   win_idx;
  logic [IW-1:0]   cand_idx;
  logic            win_found;
  logic [NREQ-1:0] gnt_d;
  logic            owner_req;

`ifdef ARB_WATCHDOG_EN
  logic [7:0] hold_q, hold_d;
  logic       timeout_d;
`endif

  // Scan starts just after the previous owner, so it gets lowest priority.
  always_comb begin
    win_idx   = last_q;
    win_found = 1'b0;
    cand_idx  = '0;
    for (int unsigned off = 1; off <= NREQ; off++) begin
      cand_idx = IW'((32'(last_q) + off) % NREQ);
      if (!win_found && req[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  assign owner_req = req[last_q];

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt;
    last_d  = last_q;
`ifdef ARB_WATCHDOG_EN
    hold_d    = hold_q;
    timeout_d = 1'b0;
`endif
    case (state_q)
      IDLE, GAP: begin
        if (|req) begin
          state_d = OWN;
          gnt_d   = NREQ'(1) << win_idx;
          last_d  = win_idx;
`ifdef ARB_WATCHDOG_EN
          hold_d  = 8'd0;
`endif
        end else begin
          state_d = IDLE;
          gnt_d   = '0;
        end
      end
      OWN: begin
        if (!owner_req) begin
          state_d = GAP;
          gnt_d   = '0;
        end
`ifdef ARB_WATCHDOG_EN
        // A release that coincides with the limit is an ordinary release.
        else if (hold_q == 8'(MAX_HOLD - 1)) begin
          state_d   = GAP;
          gnt_d     = '0;
          timeout_d = 1'b1;
        end else begin
          hold_d = hold_q + 8'd1;
        end
`endif
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      gnt       <= '0;
      last_q    <= IW'(NREQ - 1);
      bus_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt       <= gnt_d;
      last_q    <= last_d;
      bus_valid <= (state_d == OWN);
      busy      <= (state_d != IDLE);
    end
  end

`ifdef ARB_WATCHDOG_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      hold_q  <= 8'd0;
      timeout <= 1'b0;
    end else begin
      hold_q  <= hold_d;
      timeout <= timeout_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // Owner's address passes straight through; gnt is zero outside OWN.
  always_comb begin
    bus_addr = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt[i]) bus_addr = addr_in[i*AW +: AW];
    end
  end

endmodule

// File: tb/tb_rr_bus_arbiter.sv
// Scoreboarded directed bench for rr_bus_arbiter: each row drives one cycle and queues
// the outputs expected in that cycle; a negedge monitor pops and compares.
module tb_rr_bus_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned AW   = 8;

  logic              clock = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req;
  logic [NREQ*AW-1:0] addr_in;
  logic [NREQ-1:0]   gnt;
  logic [AW-1:0]     bus_addr;
  logic              bus_valid;
  logic              busy;
  logic              timeout;

  typedef struct packed {
    logic [NREQ-1:0] gnt;
    logic            valid;
    logic [AW-1:0]   addr;
    logic            busy;
    logic            to;
  } obs_t;

  obs_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   row_num  = 0;

  rr_bus_arbiter #(.NREQ(NREQ), .AW(AW), .MAX_HOLD(16)) dut (
    .clock    (clock),
    .reset    (reset),
    .req      (req),
    .addr_in  (addr_in),
    .gnt      (gnt),
    .bus_addr (bus_addr),
    .bus_valid(bus_valid),
    .busy     (busy),
    .timeout  (timeout)
  );

  always #5 clock = ~clock;

  // One cycle: apply inputs after the edge, queue outputs expected before the next edge.
  task automatic row(input logic r, input logic [NREQ-1:0] q, input logic [NREQ-1:0] g,
                     input logic b, input logic t);
    obs_t e;
    @(posedge clock);
    #1;
    reset = r;
    req   = q;
    e.gnt   = g;
    e.valid = |g;
    e.addr  = '0;
    for (int i = 0; i < NREQ; i++) if (g[i]) e.addr = addr_in[i*AW +: AW];
    e.busy = b;
    e.to   = t;
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    obs_t e, a;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = '{gnt: gnt, valid: bus_valid, addr: bus_addr, busy: busy, to: timeout};
        row_num++;
        checks++;
        if (a !== e) begin
          failures++;
          $display("FAIL row%0d t=%0t: got gnt=%b valid=%b addr=%h busy=%b timeout=%b, want gnt=%b valid=%b addr=%h busy=%b timeout=%b",
                   row_num, $time, a.gnt, a.valid, a.addr, a.busy, a.to,
                   e.gnt, e.valid, e.addr, e.busy, e.to);
        end
      end
    end
  end

  initial begin : stim
    logic [NREQ-1:0] oh;
    reset   = 1'b1;
    req     = 4'b1111;
    addr_in = {8'h3C, 8'hA5, 8'h5A, 8'hC3};
    repeat (2) @(posedge clock);

    // Reset state with all requests held through reset.
    row(1, 4'b1111, 4'b0000, 0, 0);
    row(1, 4'b1111, 4'b0000, 0, 0);
    row(0, 4'b1111, 4'b0000, 0, 0);

    // Everyone requesting; each owner keeps the bus 3 cycles: order 0,1,2,3,0.
    for (int o = 0; o < 5; o++) begin
      oh = 4'b0001 << (o % 4);
      row(0, 4'b1111, oh, 1, 0);
      row(0, 4'b1111, oh, 1, 0);
      row(0, 4'b1111 & ~oh, oh, 1, 0);
      if (o < 4) row(0, 4'b1111, 4'b0000, 1, 0);
      else       row(0, 4'b0000, 4'b0000, 1, 0);
    end
    row(0, 4'b0000, 4'b0000, 0, 0);

    // Lone requester 2; non-owner requests ignored; bus_addr follows addr_in live.
    row(0, 4'b0100, 4'b0000, 0, 0);
    row(0, 4'b0111, 4'b0100, 1, 0);
    @(posedge clock);
    #1;
    addr_in[2*AW +: AW] = 8'h7E;
    exp_q.push_back('{gnt: 4'b0100, valid: 1'b1, addr: 8'h7E, busy: 1'b1, to: 1'b0});
    req = 4'b0000;
    row(0, 4'b0000, 4'b0000, 1, 0);
    row(0, 4'b0000, 4'b0000, 0, 0);
    addr_in[2*AW +: AW] = 8'hA5;

    // Owner 1 releases with 1 and 3 requesting in the gap: 3 wins, then 1.
    row(0, 4'b0010, 4'b0000, 0, 0);
    row(0, 4'b0010, 4'b0010, 1, 0);
    row(0, 4'b1000, 4'b0010, 1, 0);
    row(0, 4'b1010, 4'b0000, 1, 0);
    row(0, 4'b1010, 4'b1000, 1, 0);
    row(0, 4'b0010, 4'b1000, 1, 0);
    row(0, 4'b0010, 4'b0000, 1, 0);

    // Reset while 1 owns: everything drops with no gap, then 0 wins over 1.
    row(1, 4'b0010, 4'b0010, 1, 0);
    row(0, 4'b0011, 4'b0000, 0, 0);
    row(0, 4'b0011, 4'b0001, 1, 0);
    row(0, 4'b0010, 4'b0001, 1, 0);
    row(0, 4'b0010, 4'b0000, 1, 0);
    row(0, 4'b0000, 4'b0010, 1, 0);
    row(0, 4'b0000, 4'b0000, 1, 0);
    row(0, 4'b0000, 4'b0000, 0, 0);

`ifdef ARB_WATCHDOG_EN
    // Held past the limit: 16 granted cycles, a timeout gap, then regranted.
    row(0, 4'b0001, 4'b0000, 0, 0);
    for (int i = 0; i < 16; i++) row(0, 4'b0001, 4'b0001, 1, 0);
    row(0, 4'b0001, 4'b0000, 1, 1);
    row(0, 4'b0000, 4'b0001, 1, 0);
    row(0, 4'b0000, 4'b0000, 1, 0);
    row(0, 4'b0000, 4'b0000, 0, 0);
    // Release on the 16th owned cycle is a normal release.
    row(0, 4'b0001, 4'b0000, 0, 0);
    for (int i = 0; i < 15; i++) row(0, 4'b0001, 4'b0001, 1, 0);
    row(0, 4'b0000, 4'b0001, 1, 0);
    row(0, 4'b0000, 4'b0000, 1, 0);
    row(0, 4'b0000, 4'b0000, 0, 0);
`else
    // Without the watchdog a grant is held indefinitely.
    row(0, 4'b1000, 4'b0000, 0, 0);
    for (int i = 0; i < 20; i++) row(0, 4'b1000, 4'b1000, 1, 0);
    row(0, 4'b0000, 4'b1000, 1, 0);
    row(0, 4'b0000, 4'b0000, 1, 0);
    row(0, 4'b0000, 4'b0000, 0, 0);
`endif

    repeat (3) @(negedge clock);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expected observations left, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rr_bus_arbiter.md
# rr_bus_arbiter

Round-robin arbiter that shares the 8-bit address bus among `NREQ` requesters. It grants exactly one requester at a time and muxes that requester's address onto the shared bus. It holds the grant until the owner releases, then inserts a one-cycle bus turnaround. It sits between the requesting blocks and the shared address port, and replaces per-requester fixed-priority grant logic.

## Interface
- `NREQ`, 4: number of requesters; legal range 2..8.
- `AW`, 8: address width.
- `MAX_HOLD`, 16: watchdog hold limit in cycles; used only with `ARB_WATCHDOG_EN`; legal range 2..255.

Ports (name, direction, width, meaning):
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  reset, synchronous, active-high.
- `req`  in  NREQ  request per requester; held high for as long as the bus is wanted.
- `addr_in`  in  NREQ*AW  packed requester addresses; requester i occupies bits [i*AW +: AW].
- `gnt`  out  NREQ  one-hot grant, registered.
- `bus_addr`  out  AW  shared bus address.
- `bus_valid`  out  1  bus owned this cycle.
- `busy`  out  1  state is not IDLE.
- `timeout`  out  1  one-cycle pulse when a grant is revoked by the watchdog.

## Operation
- FSM states: IDLE, OWN, GAP.
- IDLE:
  - `|req` → OWN, with `gnt` = the winner.
  - Otherwise stay in IDLE.
- Winner selection:
  - Scan starts at `(last+1) mod NREQ` and takes the first asserted `req`.
  - `last` resets to NREQ-1, so requester 0 has highest priority after reset.
  - `last` is loaded with the winner on entry to OWN.
- OWN:
  - Exactly one `gnt` bit is set.
  - `bus_addr` = `addr_in` slice of the owner (combinational mux from the current input).
  - `bus_valid`=1.
- OWN → GAP when `req[owner]`=0. `gnt` is all-zero from the next cycle.
- GAP: always lasts exactly one cycle, with `gnt`=0, `bus_valid`=0 and `bus_addr`=0. Arbitration in GAP is identical to IDLE: `|req` → OWN with a new winner, otherwise → IDLE.
- Fairness: a releasing owner that re-requests immediately is granted again only if no other `req` bit is set during GAP.
- Changes to `req` bits of non-owners during OWN have no effect.
- `busy` = (state != IDLE).
- Reset values:
  - state IDLE
  - `gnt`=0
  - `bus_addr`=0
  - `bus_valid`=0
  - `busy`=0
  - `timeout`=0
  - `last`=NREQ-1
  - `hold_cnt`=0
- Reset mid-OWN: the grant drops at that edge. No GAP cycle and no `timeout` pulse are produced.

## Timing
- Grant latency: `req` first high in cycle k while IDLE/GAP → `gnt` high in cycle k+1. `bus_valid`/`bus_addr` are valid in cycle k+1.
- Release: `req[owner]` low in cycle m → `gnt`=0 in cycle m+1 (GAP) → earliest next grant in cycle m+2.
- Back-to-back ownership handover takes 2 cycles minimum (1 GAP cycle).
- `bus_addr` follows `addr_in` of the owner combinationally during OWN; no extra register stage.
- `timeout` is registered and asserted only during the GAP cycle that follows a watchdog revoke.

## Configuration
- Macro: `ARB_WATCHDOG_EN`.
- Defined:
  - 8-bit `hold_cnt` clears on entry to OWN and increments each OWN cycle.
  - When the owner has held for `MAX_HOLD` cycles with `req` still high, the FSM goes OWN → GAP and `timeout`=1 during that GAP cycle.
  - Round-robin advances normally, so the revoked requester has lowest priority next.
  - If the release and the limit coincide, it is treated as a normal release with `timeout`=0.
  - A revoked requester still asserting `req` re-enters arbitration in GAP like any other requester.
- Undefined:
  - No counter is built.
  - Grants are held indefinitely.
  - `timeout` is tied 0.
  - `MAX_HOLD` is ignored.

## Test plan
- Reset with `req`=4'b1111 held through reset → after reset deasserts, `gnt`=0001 next cycle; each owner releases after 3 cycles → grant order 0,1,2,3,0 with 1 GAP cycle between grants.
- `req[2]` pulse alone (`addr_in` slice 2 = 8'hA5) → `gnt`=0100, `bus_addr`=8'hA5, `bus_valid`=1 one cycle after `req`; `req[2]` low → `gnt`=0 next cycle, then state IDLE and `busy`=0.
- Owner 1 releases while `req[1]` and `req[3]` are both high in GAP → `gnt`=1000 (requester 3 wins), not 0010.
- `reset` asserted during OWN with `gnt`=0010 → all outputs 0 at the next edge; `req[0]`,`req[1]` high after reset → `gnt`=0001.
- With `ARB_WATCHDOG_EN`, `MAX_HOLD`=16, `req[0]` held high → `gnt[0]` high exactly 16 cycles, then GAP with `timeout`=1 for 1 cycle, then `gnt`=0001 again if it is the only requester.
- With `ARB_WATCHDOG_EN`, `req[0]` released on the 16th OWN cycle → `timeout` stays 0.
